// File: rtl/chan_sel_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | chan_sel_reg_pkg : shared mode constants and select-width helper |
// | Revision: 1.0                                                    |
// +----------------------------------------------------------------+
package chan_sel_reg_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // A two-channel selector still needs one select bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chan_sel_reg_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_pick : rotate-priority picker, scans from last_ch+1 and wraps |
// | Revision: 1.0                                                    |
// +----------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_CH = 3,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_ch,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  idx
);

  always_comb begin
    int  cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(last_ch) + k) % NUM_CH;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = SEL_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/chan_sel_reg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | chan_sel_reg : registered N-channel selector, FIXED or RR grant  |
// | Revision: 1.0                                                    |
// +----------------------------------------------------------------+
module chan_sel_reg
  import chan_sel_reg_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 3,
  parameter int SEL_W  = sel_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  last_ch;
  logic [NUM_CH-1:0] rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic [NUM_CH-1:0] fixed_gnt;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              load_en;
  logic              xfer;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .req     (in_valid),
    .last_ch (last_ch),
    .gnt     (rr_gnt),
    .idx     (rr_idx)
  );

  // An out-of-range select grants nothing rather than falling back to ch0.
  always_comb begin
    fixed_gnt = '0;
    if (int'(sel) < NUM_CH && in_valid[sel]) begin
      fixed_gnt[sel] = 1'b1;
    end
  end

  assign grant     = (mode == MODE_RR) ? rr_gnt : fixed_gnt;
  assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign load_en   = !out_valid || out_ready;
  assign in_ready  = (rst_n && load_en) ? grant : '0;
  assign xfer      = |in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last_ch   <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_ch    <= grant_idx;
      last_ch   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chan_sel_reg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_chan_sel_reg : directed self-checking bench for chan_sel_reg  |
// | Revision: 1.0                                                    |
// +----------------------------------------------------------------+
module tb_chan_sel_reg;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 3;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;

  int n_chk  = 0;
  int n_pass = 0;

  int exp_data [3] = '{5, 2, 7};

  chan_sel_reg #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 3'b111;
    in_data   = {3'd7, 3'd2, 3'd5};
    mode      = 1'b0;
    sel       = 2'd1;
    out_ready = 1'b1;

    repeat (3) tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_ch",    32'(out_ch),    32'd0);

    // FIXED, sel=1
    rst_n = 1'b1;
    #1;
    check("fix_in_ready", 32'(in_ready), 32'b010);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fix_out_valid", 32'(out_valid), 32'd1);
      check("fix_out_data",  32'(out_data),  32'd2);
      check("fix_out_ch",    32'(out_ch),    32'd1);
      check("fix_in_ready2", 32'(in_ready),  32'b010);
    end

    // FIXED, out-of-range select drains the register
    sel = 2'd3;
    #1;
    check("oor_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("oor_out_valid", 32'(out_valid), 32'd0);
    check("oor_hold_data", 32'(out_data),  32'd2);

    // Reset, then RR rotation from ch0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode  = 1'b1;
    sel   = 2'd0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_out_ch",   32'(out_ch),   32'(k % 3));
      check("rr_out_data", 32'(out_data), 32'(exp_data[k % 3]));
    end

    // Backpressure holding ch2
    out_ready = 1'b0;
    #1;
    check("bp_in_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_ch",    32'(out_ch),    32'd2);
      check("bp_out_data",  32'(out_data),  32'd7);
      check("bp_in_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b001);
    tick();
    check("bp_release_ch",   32'(out_ch),   32'd0);
    check("bp_release_data", 32'(out_data), 32'd5);

    // FIXED sel=2 once, then RR continues from ch2
    mode = 1'b0;
    sel  = 2'd2;
    #1;
    check("ms_fix_ready", 32'(in_ready), 32'b100);
    tick();
    check("ms_fix_ch", 32'(out_ch), 32'd2);
    mode = 1'b1;
    #1;
    check("ms_rr_ready", 32'(in_ready), 32'b001);
    tick();
    check("ms_rr_ch",   32'(out_ch),   32'd0);
    check("ms_rr_data", 32'(out_data), 32'd5);

    // Reset during a stall
    out_ready = 1'b0;
    tick();
    check("st_out_valid", 32'(out_valid), 32'd1);
    check("st_last_ch",   32'(dut.last_ch), 32'd0);
    rst_n = 1'b0;
    #1;
    check("st_rst_ready", 32'(in_ready), 32'd0);
    tick();
    check("st_rst_valid",   32'(out_valid),    32'd0);
    check("st_rst_last_ch", 32'(dut.last_ch), 32'd2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("st_after_ready", 32'(in_ready), 32'b001);

    // Single requester in RR granted every cycle
    in_valid = 3'b010;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("one_in_ready", 32'(in_ready), 32'b010);
      tick();
      check("one_out_ch",   32'(out_ch),   32'd1);
      check("one_out_data", 32'(out_data), 32'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
